// File: rtl/ofmap_packetizer_if.sv
`default_nettype none
// ============================================================================
// Module   : ofmap_packetizer_if
// Purpose  : Pixel-result input stream and NoC packet output stream bundle.
// Revision : 1.0
// ============================================================================
interface ofmap_packetizer_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_row;
    logic [4:0]  in_col;
    logic        in_spike;
    logic        in_last;
    logic        noc_valid;
    logic        noc_ready;
    logic [63:0] noc_data;

    modport master (
        output in_valid, in_row, in_col, in_spike, in_last, noc_ready,
        input  in_ready, noc_valid, noc_data
    );

    modport slave (
        input  in_valid, in_row, in_col, in_spike, in_last, noc_ready,
        output in_ready, noc_valid, noc_data
    );
endinterface
`default_nettype wire

// File: rtl/ofmap_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : ofmap_packetizer
// Purpose  : Queues per-pixel spike results and emits 64-bit output NoC
//            packets plus a DONE packet per timestep. Optional range checking
//            is compiled in with OFMAP_PKT_BOUNDS_CHECK_EN.
// Revision : 1.0
// ============================================================================
module ofmap_packetizer #(
    parameter logic [3:0]  SRC_ADDR   = 4'b0001,
    parameter logic [3:0]  DST_ADDR   = 4'b0000,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned OFMAP_ROWS = 21,
    parameter int unsigned OFMAP_COLS = 21
) (
    input  wire logic           clk,
    input  wire logic           reset,
    ofmap_packetizer_if.slave   bus,
    output logic [7:0]          ts_count,
    output logic                bounds_err
);
    localparam int unsigned             c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned             c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]      c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [63:0]             c_HDR   = {DST_ADDR, SRC_ADDR, 2'b11, 54'd0};
    localparam logic [63:0]             c_DONE  = c_HDR | 64'h1FF;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SEND      = 2'd1;
    localparam logic [1:0] S_SEND_DONE = 2'd2;

    logic [11:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [63:0]         r_data;
    logic [63:0]         w_data_nxt;
    logic                r_last;
    logic                w_last_nxt;
    logic                w_ts_inc;
    logic [7:0]          r_ts_count;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_oob;
    logic                w_spike_eff;
    logic [11:0]         w_head;

    // Ready depends only on occupancy, never on a same-cycle pop.
    assign bus.in_ready = !reset && (r_count < c_DEPTH);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_spike_eff  = bus.in_spike && !w_oob;
    assign w_push       = w_accept && (w_spike_eff || bus.in_last);
    assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
    assign w_head       = r_mem[r_rd_ptr];

`ifdef OFMAP_PKT_BOUNDS_CHECK_EN
    localparam logic [5:0] c_ROWS = 6'(OFMAP_ROWS);
    localparam logic [5:0] c_COLS = 6'(OFMAP_COLS);
    logic r_bounds_err;

    assign w_oob = ({1'b0, bus.in_row} >= c_ROWS) || ({1'b0, bus.in_col} >= c_COLS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bounds_err <= 1'b0;
        end else if (w_accept && w_oob) begin
            r_bounds_err <= 1'b1;
        end
    end

    assign bounds_err = r_bounds_err;
`else
    // Range parameters only matter when checking is compiled in.
    if ((OFMAP_ROWS == 0) || (OFMAP_COLS == 0)) begin : g_no_range
    end

    assign w_oob      = 1'b0;
    assign bounds_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_row, bus.in_col, w_spike_eff, bus.in_last};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_pop) w_next_state = w_head[1] ? S_SEND : S_SEND_DONE;
            S_SEND:      if (bus.noc_ready) w_next_state = r_last ? S_SEND_DONE : S_IDLE;
            S_SEND_DONE: if (bus.noc_ready) w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // A last-only entry goes straight to DONE; a spike+last entry chains DONE after SEND.
    always_comb begin
        w_data_nxt = r_data;
        w_last_nxt = r_last;
        w_ts_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_last_nxt = w_head[0];
                    w_data_nxt = w_head[1] ? (c_HDR | {54'd0, w_head[11:2]}) : c_DONE;
                end
            end
            S_SEND: begin
                if (bus.noc_ready && r_last) w_data_nxt = c_DONE;
            end
            S_SEND_DONE: begin
                w_ts_inc = bus.noc_ready;
            end
            default: begin
                w_data_nxt = r_data;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data     <= '0;
            r_last     <= 1'b0;
            r_ts_count <= '0;
        end else begin
            r_data <= w_data_nxt;
            r_last <= w_last_nxt;
            if (w_ts_inc) r_ts_count <= r_ts_count + 8'd1;
        end
    end

    assign bus.noc_valid = (r_state != S_IDLE);
    assign bus.noc_data  = r_data;
    assign ts_count      = r_ts_count;
endmodule
`default_nettype wire

// File: tb/tb_ofmap_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofmap_packetizer
// Purpose  : Directed vector bench for ofmap_packetizer.
// Revision : 1.0
// ============================================================================
module tb_ofmap_packetizer;
    localparam int          DEPTH = 8;
    localparam logic [63:0] HDR   = 64'h01C0_0000_0000_0000;
    localparam logic [63:0] DONE  = HDR | 64'h1FF;

    typedef struct {
        logic [4:0]  row;
        logic [4:0]  col;
        logic        spike;
        logic        last;
        int          n_exp;
        logic [63:0] exp0;
        logic [63:0] exp1;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ts_count;
    logic        bounds_err;
    int          tests = 0;
    int          fails = 0;
    int          exp_ts = 0;
    logic [63:0] got_q[$];
    vec_t        vecs[8];

    ofmap_packetizer_if bus();

    ofmap_packetizer #(
        .SRC_ADDR   (4'b0001),
        .DST_ADDR   (4'b0000),
        .DEPTH      (DEPTH),
        .OFMAP_ROWS (21),
        .OFMAP_COLS (21)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .ts_count   (ts_count),
        .bounds_err (bounds_err)
    );

    always #5 clk = ~clk;

    // Inputs change only just after posedge, so a negedge sample predicts the next handshake.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.noc_valid === 1'b1 && bus.noc_ready === 1'b1)
            got_q.push_back(bus.noc_data);
    end

    function automatic logic [63:0] spk(input logic [4:0] r, input logic [4:0] c);
        return HDR | {54'd0, r, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_pixel(input logic [4:0] r, input logic [4:0] c, input logic s, input logic l);
        int n;
        n = 0;
        bus.in_row   = r;
        bus.in_col   = c;
        bus.in_spike = s;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pkt_at(input string name, input int idx, input logic [63:0] exp);
        check(name, (idx < got_q.size()) ? got_q[idx] : 64'bx, exp);
    endtask

    initial begin
        int  acc;
        int  waited;
        bit  stalled;

        vecs[0] = '{5'd3,  5'd7,  1'b1, 1'b0, 1, spk(5'd3, 5'd7),   64'd0};
        vecs[1] = '{5'd20, 5'd20, 1'b1, 1'b1, 2, spk(5'd20, 5'd20), DONE};
        vecs[2] = '{5'd0,  5'd0,  1'b0, 1'b0, 0, 64'd0,             64'd0};
        vecs[3] = '{5'd5,  5'd9,  1'b0, 1'b0, 0, 64'd0,             64'd0};
        vecs[4] = '{5'd0,  5'd0,  1'b0, 1'b1, 1, DONE,              64'd0};
        vecs[5] = '{5'd0,  5'd0,  1'b1, 1'b0, 1, spk(5'd0, 5'd0),   64'd0};
        vecs[6] = '{5'd20, 5'd0,  1'b1, 1'b1, 2, spk(5'd20, 5'd0),  DONE};
        vecs[7] = '{5'd12, 5'd17, 1'b1, 1'b0, 1, spk(5'd12, 5'd17), 64'd0};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.in_col    = '0;
        bus.in_spike  = 1'b0;
        bus.in_last   = 1'b0;
        bus.noc_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("rst_noc_valid", 64'(bus.noc_valid), 64'd0);
        check("rst_noc_data",  bus.noc_data,       64'd0);
        check("rst_ts_count",  64'(ts_count),      64'd0);
        check("rst_bounds",    64'(bounds_err),    64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", 64'(bus.in_ready), 64'd1);

        // First packet latency: accepted at edge N, valid from edge N+1.
        bus.noc_ready = 1'b1;
        send_pixel(5'd3, 5'd7, 1'b1, 1'b0);
        check("lat_valid_n",  64'(bus.noc_valid), 64'd0);
        tick();
        check("lat_valid_n1", 64'(bus.noc_valid), 64'd1);
        check("lat_data",     bus.noc_data,       64'h01C0_0000_0000_0067);
        repeat (6) tick();

        for (int v = 0; v < 8; v++) begin
            got_q.delete();
            send_pixel(vecs[v].row, vecs[v].col, vecs[v].spike, vecs[v].last);
            repeat (8) tick();
            check($sformatf("vec%0d_count", v), 64'(got_q.size()), 64'(vecs[v].n_exp));
            if (vecs[v].n_exp > 0) pkt_at($sformatf("vec%0d_pkt0", v), 0, vecs[v].exp0);
            if (vecs[v].n_exp > 1) pkt_at($sformatf("vec%0d_pkt1", v), 1, vecs[v].exp1);
            if (vecs[v].last) exp_ts++;
            check($sformatf("vec%0d_ts", v), 64'(ts_count), 64'(exp_ts));
        end

        // Back-pressure: one entry parks in the output register, DEPTH more fill the FIFO.
        bus.noc_ready = 1'b0;
        got_q.delete();
        acc     = 0;
        stalled = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.in_row   = 5'(i);
            bus.in_col   = 5'(i + 1);
            bus.in_spike = 1'b1;
            bus.in_last  = 1'b0;
            bus.in_valid = 1'b1;
            waited = 0;
            while (!bus.in_ready && waited < 50) begin
                if (waited == 4 && !stalled) begin
                    stalled = 1'b1;
                    check("full_accepts", 64'(acc), 64'(DEPTH + 1));
                    check("full_hold_valid", 64'(bus.noc_valid), 64'd1);
                    check("full_hold_data", bus.noc_data, spk(5'd0, 5'd1));
                    bus.noc_ready = 1'b1;
                end
                tick();
                waited++;
            end
            if (waited >= 50) begin
                tests++;
                fails++;
                $display("FAIL full_timeout: got in_ready=0 expected 1 within 50 cycles");
            end
            tick();
            acc++;
        end
        bus.in_valid = 1'b0;
        check("full_stalled", 64'(stalled), 64'd1);
        repeat (40) tick();
        check("full_count", 64'(got_q.size()), 64'd12);
        for (int i = 0; i < 12; i++)
            pkt_at($sformatf("full_pkt%0d", i), i, spk(5'(i), 5'(i + 1)));

        // Reset while a packet is in flight and more are queued.
        bus.noc_ready = 1'b0;
        send_pixel(5'd4, 5'd4, 1'b1, 1'b1);
        send_pixel(5'd6, 5'd6, 1'b1, 1'b0);
        tick();
        check("inflight_valid", 64'(bus.noc_valid), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(bus.noc_valid), 64'd0);
        check("async_rst_ready", 64'(bus.in_ready),  64'd0);
        check("async_rst_data",  bus.noc_data,       64'd0);
        tick();
        tick();
        reset  = 1'b0;
        exp_ts = 0;
        tick();
        check("rel_ready", 64'(bus.in_ready), 64'd1);
        check("rel_ts",    64'(ts_count),     64'd0);
        got_q.delete();
        bus.noc_ready = 1'b1;
        repeat (10) tick();
        check("no_stale_pkts", 64'(got_q.size()), 64'd0);

        // Out-of-range row.
        got_q.delete();
        send_pixel(5'd21, 5'd0, 1'b1, 1'b1);
        repeat (8) tick();
        exp_ts++;
`ifdef OFMAP_PKT_BOUNDS_CHECK_EN
        check("oob_count", 64'(got_q.size()), 64'd1);
        pkt_at("oob_done", 0, DONE);
        check("oob_err", 64'(bounds_err), 64'd1);
`else
        check("oob_count", 64'(got_q.size()), 64'd2);
        pkt_at("oob_spike", 0, spk(5'd21, 5'd0));
        pkt_at("oob_done",  1, DONE);
        check("oob_err", 64'(bounds_err), 64'd0);
`endif
        check("oob_ts", 64'(ts_count), 64'(exp_ts));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end
endmodule
`default_nettype wire
